// File: rtl/alu_pkg.sv
// Shared ALU opcodes, arbiter FSM states and opcode legality check.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: AND, OR, ADD, SUB, SLT with zero/overflow/carry flags.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out
);

  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        add_ovf;

  assign sub     = (op == OP_SUB) || (op == OP_SLT);
  assign b_eff   = sub ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, b_eff} + {32'b0, sub};
  assign add_ovf = (a[31] == b_eff[31]) && (sum[31] != a[31]);

  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD, OP_SUB: begin
        result    = sum[31:0];
        overflow  = add_ovf;
        carry_out = sum[32];
      end
      // Signed less-than: sign of the difference corrected by overflow.
      OP_SLT: result = {31'b0, sum[31] ^ add_ovf};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping upward.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      int unsigned j;
      j = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters, one transaction in flight.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
`ifdef ALU_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [32*NUM_REQ-1:0]    req_a,
  input  logic [32*NUM_REQ-1:0]    req_b,
  input  logic [3*NUM_REQ-1:0]     req_op,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [31:0]              rsp_result,
  output logic                     rsp_zero,
  output logic                     rsp_overflow,
  output logic                     rsp_carry,
`ifdef ALU_ARB_STATS_EN
  output logic [CNT_W*NUM_REQ-1:0] grant_cnt,
`endif
  output logic                     rsp_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e               state_q;
  logic [IdxW-1:0]      idx_q, ptr_q;
  logic [31:0]          a_q, b_q;
  logic [2:0]           op_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [31:0]          rsp_result_q;
  logic                 rsp_zero_q, rsp_overflow_q, rsp_carry_q, rsp_err_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IdxW-1:0]      arb_idx;
  logic                 req_hs;
  logic [31:0]          alu_result;
  logic                 alu_zero, alu_overflow, alu_carry;
  logic                 op_legal;
  logic [IdxW-1:0]      ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  alu u_alu (
    .a         (a_q),
    .b         (b_q),
    .op        (op_q),
    .result    (alu_result),
    .zero      (alu_zero),
    .overflow  (alu_overflow),
    .carry_out (alu_carry)
  );

  assign req_ready = (state_q == IDLE) ? arb_grant : '0;
  assign req_hs    = |req_ready;
  assign op_legal  = is_legal_op(op_q);
  assign ptr_next  = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      ptr_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      rsp_valid_q    <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_hs) begin
            a_q     <= req_a[32*arb_idx +: 32];
            b_q     <= req_b[32*arb_idx +: 32];
            op_q    <= req_op[3*arb_idx +: 3];
            idx_q   <= arb_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // Illegal opcodes report zero result and clear flags, only err is raised.
          rsp_result_q   <= op_legal ? alu_result : '0;
          rsp_zero_q     <= op_legal & alu_zero;
          rsp_overflow_q <= op_legal & alu_overflow;
          rsp_carry_q    <= op_legal & alu_carry;
          rsp_err_q      <= ~op_legal;
          rsp_valid_q    <= NUM_REQ'(1) << idx_q;
          ptr_q          <= ptr_next;
          state_q        <= RESP;
        end
        RESP: begin
          if (rsp_ready[idx_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_err      = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (req_valid[g] && req_ready[g] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign grant_cnt[CNT_W*g +: CNT_W] = cnt_q;
  end
`endif

endmodule
